// File: rtl/risc_spm_pkg.sv
// risc_spm_pkg: opcodes, controller state encoding and bus-mux select codes shared by
// the RISC SPM control unit and datapath muxes. Rev 1.0
`default_nettype none

package risc_spm_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_NOT = 4'd4;
  localparam logic [3:0] OP_RD  = 4'd5;
  localparam logic [3:0] OP_WR  = 4'd6;
  localparam logic [3:0] OP_BR  = 4'd7;
  localparam logic [3:0] OP_BRZ = 4'd8;

  localparam logic [2:0] SEL1_R0 = 3'd0;
  localparam logic [2:0] SEL1_R1 = 3'd1;
  localparam logic [2:0] SEL1_R2 = 3'd2;
  localparam logic [2:0] SEL1_R3 = 3'd3;
  localparam logic [2:0] SEL1_PC = 3'd4;

  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  typedef enum logic [3:0] {
    S_idle = 4'd0,
    S_fet1 = 4'd1,
    S_fet2 = 4'd2,
    S_dec  = 4'd3,
    S_ex1  = 4'd4,
    S_rd1  = 4'd5,
    S_rd2  = 4'd6,
    S_wr1  = 4'd7,
    S_wr2  = 4'd8,
    S_br1  = 4'd9,
    S_br2  = 4'd10,
    S_halt = 4'd11
  } state_t;

endpackage

`default_nettype wire

// File: rtl/control_unit_if.sv
// control_unit_if: control-unit <-> datapath signals; master = controller, slave = datapath.
// Rev 1.0
`default_nettype none

interface control_unit_if #(parameter int ws = 8);

  logic [ws-1:0] instruction;
  logic          zero;
  logic          Load_R0;
  logic          Load_R1;
  logic          Load_R2;
  logic          Load_R3;
  logic          Load_PC;
  logic          Inc_PC;
  logic          Load_IR;
  logic          Load_Add_R;
  logic          Load_Reg_Y;
  logic          Load_Reg_Z;
  logic [2:0]    Sel_Bus_1_Mux;
  logic [1:0]    Sel_Bus_2_Mux;
  logic          write;
  logic          halted;

  modport master (
    input  instruction, zero,
    output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC, Load_IR, Load_Add_R,
           Load_Reg_Y, Load_Reg_Z, Sel_Bus_1_Mux, Sel_Bus_2_Mux, write, halted
  );

  modport slave (
    output instruction, zero,
    input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC, Load_IR, Load_Add_R,
           Load_Reg_Y, Load_Reg_Z, Sel_Bus_1_Mux, Sel_Bus_2_Mux, write, halted
  );

endinterface

`default_nettype wire

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer for the 8-bit RISC SPM.
// Rev 1.0
`default_nettype none

module control_unit
  import risc_spm_pkg::*;
#(
  parameter int ws = 8
) (
  input  logic             clk,
  input  logic             rst,
  control_unit_if.master   cu
);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] w_opcode;
  logic [1:0] w_src;
  logic [1:0] w_dest;
  logic [3:0] w_ld_r;
  logic       w_load_pc;
  logic       w_inc_pc;
  logic       w_load_ir;
  logic       w_load_add_r;
  logic       w_load_reg_y;
  logic       w_load_reg_z;
  logic [2:0] w_sel1;
  logic [1:0] w_sel2;
  logic       w_write;
  logic       w_halted;

  assign w_opcode = cu.instruction[ws-1:ws-4];
  assign w_src    = cu.instruction[3:2];
  assign w_dest   = cu.instruction[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_idle;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_ld_r       = 4'b0000;
    w_load_pc    = 1'b0;
    w_inc_pc     = 1'b0;
    w_load_ir    = 1'b0;
    w_load_add_r = 1'b0;
    w_load_reg_y = 1'b0;
    w_load_reg_z = 1'b0;
    w_sel1       = SEL1_R0;
    w_sel2       = SEL2_ALU;
    w_write      = 1'b0;
    w_halted     = 1'b0;
    case (r_state)
      S_idle: w_next = S_fet1;
      S_fet1: begin
        w_sel1 = SEL1_PC; w_sel2 = SEL2_BUS1; w_load_add_r = 1'b1; w_next = S_fet2;
      end
      S_fet2: begin
        w_sel2 = SEL2_MEM; w_load_ir = 1'b1; w_inc_pc = 1'b1; w_next = S_dec;
      end
      S_dec: begin
        case (w_opcode)
          OP_NOP: w_next = S_fet1;
          OP_ADD, OP_SUB, OP_AND: begin
            w_sel1 = {1'b0, w_src}; w_sel2 = SEL2_BUS1; w_load_reg_y = 1'b1; w_next = S_ex1;
          end
          OP_NOT: begin
            w_sel1 = {1'b0, w_src}; w_sel2 = SEL2_ALU; w_load_reg_z = 1'b1;
            w_ld_r[w_dest] = 1'b1; w_next = S_fet1;
          end
          OP_RD, OP_WR, OP_BR: begin
            w_sel1 = SEL1_PC; w_sel2 = SEL2_BUS1; w_load_add_r = 1'b1;
            if (w_opcode == OP_RD)      w_next = S_rd1;
            else if (w_opcode == OP_WR) w_next = S_wr1;
            else                        w_next = S_br1;
          end
          OP_BRZ: begin
            // Not taken: step PC past the operand byte instead of loading it.
            if (cu.zero) begin
              w_sel1 = SEL1_PC; w_sel2 = SEL2_BUS1; w_load_add_r = 1'b1; w_next = S_br1;
            end else begin
              w_inc_pc = 1'b1; w_next = S_fet1;
            end
          end
          default: w_next = S_halt;
        endcase
      end
      S_ex1: begin
        w_sel1 = {1'b0, w_dest}; w_sel2 = SEL2_ALU; w_load_reg_z = 1'b1;
        w_ld_r[w_dest] = 1'b1; w_next = S_fet1;
      end
      S_rd1: begin
        w_sel2 = SEL2_MEM; w_load_add_r = 1'b1; w_inc_pc = 1'b1; w_next = S_rd2;
      end
      S_rd2: begin
        w_sel2 = SEL2_MEM; w_ld_r[w_dest] = 1'b1; w_next = S_fet1;
      end
      S_wr1: begin
        w_sel2 = SEL2_MEM; w_load_add_r = 1'b1; w_inc_pc = 1'b1; w_next = S_wr2;
      end
      S_wr2: begin
        w_sel1 = {1'b0, w_src}; w_write = 1'b1; w_next = S_fet1;
      end
      S_br1: begin
        w_sel2 = SEL2_MEM; w_load_add_r = 1'b1; w_next = S_br2;
      end
      S_br2: begin
        w_sel2 = SEL2_MEM; w_load_pc = 1'b1; w_next = S_fet1;
      end
      S_halt: begin
        w_halted = 1'b1; w_next = S_halt;
      end
      default: w_next = S_idle;
    endcase
  end

  assign cu.Load_R0       = w_ld_r[0];
  assign cu.Load_R1       = w_ld_r[1];
  assign cu.Load_R2       = w_ld_r[2];
  assign cu.Load_R3       = w_ld_r[3];
  assign cu.Load_PC       = w_load_pc;
  assign cu.Inc_PC        = w_inc_pc;
  assign cu.Load_IR       = w_load_ir;
  assign cu.Load_Add_R    = w_load_add_r;
  assign cu.Load_Reg_Y    = w_load_reg_y;
  assign cu.Load_Reg_Z    = w_load_reg_z;
  assign cu.Sel_Bus_1_Mux = w_sel1;
  assign cu.Sel_Bus_2_Mux = w_sel2;
  assign cu.write         = w_write;
  assign cu.halted        = w_halted;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// tb_control_unit: vector table, directed corner sequences and random instruction stream
// checked against a per-instruction micro-op model of the control unit.
`default_nettype none

module tb_control_unit;

  // {Load_R3..R0, Load_PC, Inc_PC, Load_IR, Load_Add_R, Load_Reg_Y, Load_Reg_Z, Sel1, Sel2, write, halted}
  typedef logic [16:0] outv_t;

  typedef struct {
    string      name;
    logic [7:0] ins;
    logic       z;
    outv_t      dec;
    int         lat;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    checks = 0;
  int    errors = 0;
  outv_t exp_q[$];
  outv_t act;
  vec_t  tbl[10];

  control_unit_if #(.ws(8)) bus ();

  control_unit #(.ws(8)) dut (
    .clk (clk),
    .rst (rst),
    .cu  (bus)
  );

  always #5 clk = ~clk;

  assign act = {bus.Load_R3, bus.Load_R2, bus.Load_R1, bus.Load_R0, bus.Load_PC, bus.Inc_PC,
                bus.Load_IR, bus.Load_Add_R, bus.Load_Reg_Y, bus.Load_Reg_Z,
                bus.Sel_Bus_1_Mux, bus.Sel_Bus_2_Mux, bus.write, bus.halted};

  function automatic outv_t pk(input logic [3:0] ld, input logic ldpc, input logic inc,
                               input logic ir, input logic addr, input logic y, input logic z,
                               input logic [2:0] s1, input logic [1:0] s2, input logic wr,
                               input logic h);
    return {ld, ldpc, inc, ir, addr, y, z, s1, s2, wr, h};
  endfunction

  function automatic outv_t f1();
    return pk(4'b0, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0);
  endfunction

  function automatic outv_t f2();
    return pk(4'b0, 0, 1, 1, 0, 0, 0, 3'd0, 2'd2, 0, 0);
  endfunction

  task automatic chk(input string name, input outv_t a, input outv_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  // Expected output per cycle from fetch through the last execute cycle.
  task automatic build(input logic [7:0] ins, input logic z);
    logic [3:0] op;
    logic [1:0] src;
    logic [1:0] dst;
    logic [3:0] ld;
    outv_t      fetch_op;
    op  = ins[7:4];
    src = ins[3:2];
    dst = ins[1:0];
    ld  = 4'b0001 << dst;
    fetch_op = f1();
    exp_q.delete();
    exp_q.push_back(f1());
    exp_q.push_back(f2());
    case (op)
      4'd1, 4'd2, 4'd3: begin
        exp_q.push_back(pk(4'b0, 0, 0, 0, 0, 1, 0, {1'b0, src}, 2'd1, 0, 0));
        exp_q.push_back(pk(ld, 0, 0, 0, 0, 0, 1, {1'b0, dst}, 2'd0, 0, 0));
      end
      4'd4: exp_q.push_back(pk(ld, 0, 0, 0, 0, 0, 1, {1'b0, src}, 2'd0, 0, 0));
      4'd5: begin
        exp_q.push_back(fetch_op);
        exp_q.push_back(pk(4'b0, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
        exp_q.push_back(pk(ld, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0));
      end
      4'd6: begin
        exp_q.push_back(fetch_op);
        exp_q.push_back(pk(4'b0, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
        exp_q.push_back(pk(4'b0, 0, 0, 0, 0, 0, 0, {1'b0, src}, 2'd0, 1, 0));
      end
      4'd7, 4'd8: begin
        if (op == 4'd7 || z) begin
          exp_q.push_back(fetch_op);
          exp_q.push_back(pk(4'b0, 0, 0, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
          exp_q.push_back(pk(4'b0, 1, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0));
        end else begin
          exp_q.push_back(pk(4'b0, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0));
        end
      end
      default: exp_q.push_back('0);
    endcase
  endtask

  // Entered and left at #1 after the edge that starts S_fet1.
  task automatic run_instr(input string name, input logic [7:0] ins, input logic z);
    bus.instruction = ins;
    bus.zero        = z;
    build(ins, z);
    foreach (exp_q[i]) begin
      chk($sformatf("%s cyc%0d", name, i), act, exp_q[i]);
      @(posedge clk) #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    chk("reset asserted", act, '0);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("reset release cycle", act, '0);
    @(posedge clk) #1;
  endtask

  initial begin
    int lat;
    logic [7:0] ins;
    logic       z;

    tbl[0] = '{"NOP",     8'h00, 1'b0, pk(4'b0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0), 3};
    tbl[1] = '{"ADD",     8'h1B, 1'b0, pk(4'b0, 0, 0, 0, 0, 1, 0, 3'd2, 2'd1, 0, 0), 4};
    tbl[2] = '{"SUB",     8'h2B, 1'b1, pk(4'b0, 0, 0, 0, 0, 1, 0, 3'd2, 2'd1, 0, 0), 4};
    tbl[3] = '{"AND",     8'h3E, 1'b0, pk(4'b0, 0, 0, 0, 0, 1, 0, 3'd3, 2'd1, 0, 0), 4};
    tbl[4] = '{"NOT",     8'h46, 1'b0, pk(4'b0100, 0, 0, 0, 0, 0, 1, 3'd1, 2'd0, 0, 0), 3};
    tbl[5] = '{"RD",      8'h52, 1'b0, pk(4'b0, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0), 5};
    tbl[6] = '{"WR",      8'h64, 1'b0, pk(4'b0, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0), 5};
    tbl[7] = '{"BR",      8'h70, 1'b0, pk(4'b0, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0), 5};
    tbl[8] = '{"BRZ tkn", 8'h80, 1'b1, pk(4'b0, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0), 5};
    tbl[9] = '{"BRZ nt",  8'h80, 1'b0, pk(4'b0, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0), 3};

    bus.instruction = 8'h00;
    bus.zero        = 1'b0;
    #2;
    do_reset();
    chk("first fetch", act, f1());

    // Vector table: decode-cycle outputs and latency to the next fetch.
    foreach (tbl[v]) begin
      bus.instruction = tbl[v].ins;
      bus.zero        = tbl[v].z;
      do_reset();
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk) #1;
        if (k == 2) chk($sformatf("%s dec", tbl[v].name), act, tbl[v].dec);
        if (k >= 2 && act === f2()) begin
          lat = k - 1;
          break;
        end
      end
      checks++;
      if (lat != tbl[v].lat) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", tbl[v].name, lat, tbl[v].lat);
      end
    end

    // Abort RD in S_rd1 with an asynchronous reset.
    do_reset();
    bus.instruction = 8'h52;
    bus.zero        = 1'b0;
    repeat (3) @(posedge clk) #1;
    chk("rd1 before abort", act, pk(4'b0, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
    do_reset();
    chk("fetch after abort", act, f1());

    run_instr("ADD R2,R3", 8'h1B, 1'b0);
    run_instr("RD R2", 8'h52, 1'b1);
    run_instr("WR R1", 8'h64, 1'b0);
    run_instr("BRZ nt", 8'h80, 1'b0);
    run_instr("BRZ tkn", 8'h80, 1'b1);
    chk("fetch after BRZ", act, f1());

    // Random legal instruction stream.
    for (int n = 0; n < 200; n++) begin
      ins = {4'($urandom_range(0, 8)), 4'($urandom_range(0, 15))};
      z   = 1'($urandom_range(0, 1));
      run_instr($sformatf("rand%0d %h", n, ins), ins, z);
    end

    // Illegal opcode halts until reset.
    run_instr("illegal F0", 8'hF0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      bus.instruction = 8'($urandom);
      bus.zero        = 1'($urandom_range(0, 1));
      chk($sformatf("halt cyc%0d", k), act, pk(4'b0, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 1));
      @(posedge clk) #1;
    end
    bus.instruction = 8'h00;
    do_reset();
    chk("fetch after halt reset", act, f1());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
